free_reg_list: RTL and testbench
================================

Name: free_reg_list

Overview:
- Tracks which physical registers are free. There are two independent circular free lists: D (data) registers and S (status) registers.
- Rename pops a free physical register for each instruction that writes a destination.
- Commit pushes back the previous mapping, using the reorder buffer checkin interface (return_r/r_addr, return_s/s_addr).
- Branch checkpoints snapshot the allocation pointers; a mispredict restore rewinds them, reclaiming registers allocated on the wrong path.

Parameters:
- NUM_D_REG, 32, physical D registers (power of two)
- NUM_S_REG, 16, physical S registers (power of two)
- NUM_ARCH_D, 8, architectural D registers; physical 0..NUM_ARCH_D-1 are mapped at reset
- NUM_ARCH_S, 4, architectural S registers; physical 0..NUM_ARCH_S-1 are mapped at reset
- NUM_CKPT, 4, checkpoint slots (power of two)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (polarity and synchronicity fixed)
- alloc_r  in  1  pop one D register this cycle
- alloc_s  in  1  pop one S register this cycle
- rw_addr  out  clog2(NUM_D_REG)  D register at the D head; valid when !r_empty
- rs_addr  out  clog2(NUM_S_REG)  S register at the S head; valid when !s_empty
- r_empty  out  1  D list has zero entries
- s_empty  out  1  S list has zero entries
- return_r  in  1  push r_addr onto the D tail (from ROB checkin)
- r_addr  in  clog2(NUM_D_REG)  returned D register
- return_s  in  1  push s_addr onto the S tail
- s_addr  in  clog2(NUM_S_REG)  returned S register
- ckpt_save  in  1  snapshot both heads into slot ckpt_id
- ckpt_restore  in  1  rewind both heads from slot ckpt_id
- ckpt_id  in  clog2(NUM_CKPT)  checkpoint slot
- r_count  out  clog2(NUM_D_REG)+1  D entries available
- s_count  out  clog2(NUM_S_REG)+1  S entries available
- overflow  out  1  sticky error flag

Behaviour:
- Storage and pointers:
  - Each list has NUM_x_REG entries.
  - head and tail are clog2(NUM_x_REG)+1 bits wide.
  - Index = pointer modulo NUM_x_REG; natural wrap.
  - count = tail - head (unsigned, pointer width); empty = (count == 0).
- Reset (rst high at a clk edge):
  - D list entry i = NUM_ARCH_D + i for i < NUM_D_REG - NUM_ARCH_D.
  - D head = 0, D tail = NUM_D_REG - NUM_ARCH_D.
  - S list initialised the same way with the S parameters.
  - All checkpoint slots = 0. overflow = 0.
  - After reset: rw_addr = 8, rs_addr = 4, r_count = 24, s_count = 12, both empty flags = 0.
  - Reset mid-operation discards all state.
- Head outputs: rw_addr, rs_addr, empty flags and counts are combinational from current state. No bypass of same-cycle returns.
- Alloc:
  - When alloc_x and !x_empty: head increments at the edge; the consumer samples x_addr in the same cycle.
  - Alloc while empty is ignored; head is unchanged. Upstream stalls on empty.
- Return:
  - When return_x and count < NUM_x_REG - NUM_ARCH_x: write the entry at tail, tail++.
  - Otherwise (excess return) the write is dropped and overflow is set; overflow clears only on rst.
- Simultaneous alloc and return on a non-empty list: both apply; count is unchanged.
- Return on an empty list with alloc in the same cycle: the alloc is ignored and the return is applied.
- ckpt_save:
  - Slot ckpt_id captures the post-edge heads, including a same-cycle alloc.
  - Rename asserts save with the branch's own alloc.
- ckpt_restore:
  - Both heads are loaded from slot ckpt_id. Tails are untouched, so same-cycle and intervening returns are kept.
  - Restore wins over alloc and over save in the same cycle; both are ignored.
- Each list is independent: the D and S lists never interact except via shared ckpt control.

Test Plan:
- Reset, then alloc_r for 24 consecutive cycles:
  - rw_addr sequence is 8..31.
  - r_empty = 1 after the 24th; r_count = 0.
  - A 25th alloc leaves the state unchanged.
- From reset, return_r with r_addr = 3 while D is full (r_count = 24) -> overflow = 1, r_count stays 24.
- Alloc 3 D registers (8, 9, 10), ckpt_save with id 1 on the third alloc, then alloc 2 more (11, 12), then ckpt_restore id 1:
  - rw_addr = 11, r_count = 21.
- Empty the D list, then same-cycle alloc_r and return_r with r_addr = 5:
  - rw_addr = 5 next cycle, r_count = 1.
  - The alloc was not performed (pointer unchanged).
- Wrap: alloc 20 and return 20 (addrs 0..19) repeatedly for 3 rounds:
  - Order is preserved across the pointer wrap.
  - r_count is always 24 at round end.
  - overflow stays 0.
- Same-cycle ckpt_restore, alloc_s and return_s with s_addr = 2:
  - The S head is taken from the slot.
  - Entry 2 is appended at the tail.
  - The alloc is ignored.

Source files
------------

// File: rtl/free_reg_list.sv
// Dual circular free lists (D and S physical registers) with shared
// checkpoint control; heads can be rewound to a saved snapshot on mispredict.
module frl_list #(
  parameter int N = 32,
  parameter int A = 8,
  parameter int C = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_i,
  input  logic                 ret_i,
  input  logic [$clog2(N)-1:0] ret_addr_i,
  input  logic                 save_i,
  input  logic                 restore_i,
  input  logic [$clog2(C)-1:0] id_i,
  output logic [$clog2(N)-1:0] head_addr_o,
  output logic                 empty_o,
  output logic [$clog2(N):0]   count_o,
  output logic                 ovf_o
);
  localparam int AW = $clog2(N);
  localparam int PW = AW + 1;

  logic [AW-1:0] mem_q [N];
  logic [PW-1:0] ckpt_q [C];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] count;
  logic          ovf_q;
  logic          ret_ok;
  logic          do_alloc;
  logic [N-1:0]  wr_en;
  logic [C-1:0]  save_en;

  assign count       = tail_q - head_q;
  assign empty_o     = (count == '0);
  assign count_o     = count;
  assign ovf_o       = ovf_q;
  assign head_addr_o = mem_q[head_q[AW-1:0]];

  // A return is only legal while fewer than the non-architectural registers are free.
  assign ret_ok   = ret_i && (count < PW'(N - A));
  assign do_alloc = alloc_i && !empty_o && !restore_i;

  for (genvar gi = 0; gi < N; gi++) begin : g_wr
    assign wr_en[gi] = ret_ok && (tail_q[AW-1:0] == AW'(gi));
  end

  for (genvar gi = 0; gi < C; gi++) begin : g_save
    assign save_en[gi] = save_i && !restore_i && (id_i == ($clog2(C))'(gi));
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (restore_i) begin
      head_d = ckpt_q[id_i];
    end else if (do_alloc) begin
      head_d = head_q + 1'b1;
    end
    if (ret_ok) begin
      tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= PW'(N - A);
      ovf_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= (i < N - A) ? AW'(A + i) : '0;
      end
      for (int i = 0; i < C; i++) begin
        ckpt_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (ret_i && !ret_ok) begin
        ovf_q <= 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (wr_en[i]) mem_q[i] <= ret_addr_i;
      end
      // Snapshot the post-edge head so a branch's own alloc is included.
      for (int i = 0; i < C; i++) begin
        if (save_en[i]) ckpt_q[i] <= head_d;
      end
    end
  end
endmodule

module free_reg_list #(
  parameter int NUM_D_REG  = 32,
  parameter int NUM_S_REG  = 16,
  parameter int NUM_ARCH_D = 8,
  parameter int NUM_ARCH_S = 4,
  parameter int NUM_CKPT   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_r,
  input  logic                         alloc_s,
  output logic [$clog2(NUM_D_REG)-1:0] rw_addr,
  output logic [$clog2(NUM_S_REG)-1:0] rs_addr,
  output logic                         r_empty,
  output logic                         s_empty,
  input  logic                         return_r,
  input  logic [$clog2(NUM_D_REG)-1:0] r_addr,
  input  logic                         return_s,
  input  logic [$clog2(NUM_S_REG)-1:0] s_addr,
  input  logic                         ckpt_save,
  input  logic                         ckpt_restore,
  input  logic [$clog2(NUM_CKPT)-1:0]  ckpt_id,
  output logic [$clog2(NUM_D_REG):0]   r_count,
  output logic [$clog2(NUM_S_REG):0]   s_count,
  output logic                         overflow
);
  logic ovf_r, ovf_s;

  frl_list #(.N(NUM_D_REG), .A(NUM_ARCH_D), .C(NUM_CKPT)) u_d_list (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (alloc_r),
    .ret_i       (return_r),
    .ret_addr_i  (r_addr),
    .save_i      (ckpt_save),
    .restore_i   (ckpt_restore),
    .id_i        (ckpt_id),
    .head_addr_o (rw_addr),
    .empty_o     (r_empty),
    .count_o     (r_count),
    .ovf_o       (ovf_r)
  );

  frl_list #(.N(NUM_S_REG), .A(NUM_ARCH_S), .C(NUM_CKPT)) u_s_list (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (alloc_s),
    .ret_i       (return_s),
    .ret_addr_i  (s_addr),
    .save_i      (ckpt_save),
    .restore_i   (ckpt_restore),
    .id_i        (ckpt_id),
    .head_addr_o (rs_addr),
    .empty_o     (s_empty),
    .count_o     (s_count),
    .ovf_o       (ovf_s)
  );

  assign overflow = ovf_r | ovf_s;
endmodule

// File: tb/tb_free_reg_list.sv
// Bench for free_reg_list: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an absolute-pointer model.
module tb_free_reg_list;
  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_r, alloc_s, return_r, return_s;
  logic       ckpt_save, ckpt_restore;
  logic [1:0] ckpt_id;
  logic [4:0] r_addr, rw_addr;
  logic [3:0] s_addr, rs_addr;
  logic       r_empty, s_empty, overflow;
  logic [5:0] r_count;
  logic [4:0] s_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  free_reg_list dut (
    .clk(clk), .rst(rst), .alloc_r(alloc_r), .alloc_s(alloc_s),
    .rw_addr(rw_addr), .rs_addr(rs_addr), .r_empty(r_empty), .s_empty(s_empty),
    .return_r(return_r), .r_addr(r_addr), .return_s(return_s), .s_addr(s_addr),
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .ckpt_id(ckpt_id),
    .r_count(r_count), .s_count(s_count), .overflow(overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_r = 0; alloc_s = 0; return_r = 0; return_s = 0;
    ckpt_save = 0; ckpt_restore = 0; ckpt_id = 0; r_addr = 0; s_addr = 0;
  endtask

  // Model: free registers are a sequence addressed by free-running pointers;
  // the pointers live modulo twice the list size and slots modulo the size.
  bit m_valid = 0;
  int dh, dt, sh, st;
  int dmem[32];
  int smem[16];
  int dck[4];
  int sck[4];
  bit m_ovf;

  always @(posedge clk) begin
    int dcnt, scnt, ndh, nsh;
    if (rst) begin
      m_valid = 1; m_ovf = 0;
      dh = 0; dt = 24; sh = 0; st = 12;
      for (int i = 0; i < 32; i++) dmem[i] = (i < 24) ? 8 + i : 0;
      for (int i = 0; i < 16; i++) smem[i] = (i < 12) ? 4 + i : 0;
      for (int i = 0; i < 4; i++) begin dck[i] = 0; sck[i] = 0; end
    end else if (m_valid) begin
      dcnt = (dt - dh) & 63;
      scnt = (st - sh) & 31;
      ndh = dh; nsh = sh;
      if (ckpt_restore) begin
        ndh = dck[ckpt_id];
        nsh = sck[ckpt_id];
      end else begin
        if (alloc_r && dcnt != 0) ndh = (dh + 1) & 63;
        if (alloc_s && scnt != 0) nsh = (sh + 1) & 31;
        if (ckpt_save) begin
          dck[ckpt_id] = ndh;
          sck[ckpt_id] = nsh;
        end
      end
      if (return_r) begin
        if (dcnt < 24) begin dmem[dt % 32] = r_addr; dt = (dt + 1) & 63; end
        else m_ovf = 1;
      end
      if (return_s) begin
        if (scnt < 12) begin smem[st % 16] = s_addr; st = (st + 1) & 31; end
        else m_ovf = 1;
      end
      dh = ndh; sh = nsh;
    end
  end

  always @(negedge clk) begin
    int dcnt, scnt;
    if (m_valid) begin
      dcnt = (dt - dh) & 63;
      scnt = (st - sh) & 31;
      chk("cmp_r_count", r_count, dcnt);
      chk("cmp_s_count", s_count, scnt);
      chk("cmp_r_empty", r_empty, dcnt == 0);
      chk("cmp_s_empty", s_empty, scnt == 0);
      chk("cmp_overflow", overflow, m_ovf);
      if (dcnt != 0) chk("cmp_rw_addr", rw_addr, dmem[dh % 32]);
      if (scnt != 0) chk("cmp_rs_addr", rs_addr, smem[sh % 16]);
    end
  end

  initial begin
    int first_rw[2];
    idle();
    rst = 1; tick(); tick(); rst = 0;
    $display("reset: rw=%0d rs=%0d rc=%0d sc=%0d", rw_addr, rs_addr, r_count, s_count);
    chk("rst_rw_addr", rw_addr, 8);
    chk("rst_rs_addr", rs_addr, 4);
    chk("rst_r_count", r_count, 24);
    chk("rst_s_count", s_count, 12);
    chk("rst_r_empty", r_empty, 0);
    chk("rst_s_empty", s_empty, 0);
    chk("rst_overflow", overflow, 0);

    return_r = 1; r_addr = 3; tick(); idle();
    $display("excess return: ovf=%0d rc=%0d", overflow, r_count);
    chk("excess_overflow", overflow, 1);
    chk("excess_r_count", r_count, 24);

    rst = 1; tick(); rst = 0;
    chk("rst_clears_ovf", overflow, 0);
    for (int i = 0; i < 24; i++) begin
      chk("alloc_seq", rw_addr, 8 + i);
      alloc_r = 1; tick();
    end
    alloc_r = 0;
    $display("drained: empty=%0d rc=%0d", r_empty, r_count);
    chk("drain_empty", r_empty, 1);
    chk("drain_count", r_count, 0);
    alloc_r = 1; tick(); alloc_r = 0;
    chk("alloc_empty_count", r_count, 0);
    chk("alloc_empty_flag", r_empty, 1);
    alloc_r = 1; return_r = 1; r_addr = 5; tick(); idle();
    $display("empty alloc+return: rw=%0d rc=%0d", rw_addr, r_count);
    chk("empty_ret_rw", rw_addr, 5);
    chk("empty_ret_count", r_count, 1);

    rst = 1; tick(); rst = 0;
    alloc_r = 1; tick(); tick();
    ckpt_save = 1; ckpt_id = 1; tick(); ckpt_save = 0;
    tick(); tick(); alloc_r = 0;
    chk("pre_restore_rw", rw_addr, 13);
    chk("pre_restore_count", r_count, 19);
    ckpt_restore = 1; ckpt_id = 1; tick(); idle();
    $display("restore: rw=%0d rc=%0d", rw_addr, r_count);
    chk("restore_rw", rw_addr, 11);
    chk("restore_count", r_count, 21);

    rst = 1; tick(); rst = 0;
    first_rw[0] = 28; first_rw[1] = 16;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 20; k++) begin alloc_r = 1; tick(); end
      alloc_r = 0;
      for (int k = 0; k < 20; k++) begin return_r = 1; r_addr = 5'(k); tick(); end
      idle();
      $display("wrap round %0d: rc=%0d ovf=%0d rw=%0d", r, r_count, overflow, rw_addr);
      chk("wrap_count", r_count, 24);
      chk("wrap_overflow", overflow, 0);
      if (r < 2) chk("wrap_next_rw", rw_addr, first_rw[r]);
    end

    rst = 1; tick(); rst = 0;
    alloc_s = 1; ckpt_save = 1; ckpt_id = 2; tick(); ckpt_save = 0;
    tick(); alloc_s = 0;
    chk("s_pre_rs", rs_addr, 6);
    chk("s_pre_count", s_count, 10);
    ckpt_restore = 1; ckpt_id = 2; alloc_s = 1; return_s = 1; s_addr = 2; tick(); idle();
    $display("s restore: rs=%0d sc=%0d", rs_addr, s_count);
    chk("s_restore_rs", rs_addr, 5);
    chk("s_restore_count", s_count, 12);
    chk("s_restore_d_rw", rw_addr, 8);
    for (int k = 0; k < 11; k++) begin alloc_s = 1; tick(); end
    alloc_s = 0;
    chk("s_tail_entry", rs_addr, 2);
    chk("s_tail_count", s_count, 1);

    rst = 1; tick(); rst = 0;
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 999) < 3);
      alloc_r      = ($urandom_range(0, 99) < 45);
      alloc_s      = ($urandom_range(0, 99) < 45);
      return_r     = ($urandom_range(0, 99) < 40);
      return_s     = ($urandom_range(0, 99) < 40);
      ckpt_save    = ($urandom_range(0, 99) < 10);
      ckpt_restore = ($urandom_range(0, 99) < 4);
      ckpt_id      = 2'($urandom_range(0, 3));
      r_addr       = 5'($urandom_range(0, 31));
      s_addr       = 4'($urandom_range(0, 15));
      tick();
    end
    idle(); rst = 0; tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
